// File: rtl/mem_access_stage_if.sv
// Data-memory handshake bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory access over req/ack with stall, timeout and
// alignment abort, producing the MEM/WB register and the branch redirect.
//
// state | meaning
// IDLE  | no access outstanding; zero-wait accesses complete here
// WAIT  | request issued, waiting for ack; counter tracks elapsed wait cycles
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         res,
   input  logic                zero,
   input  logic [31:0]         write_data_ex,
   input  logic [4:0]          write_register,
   input  logic [2:0]          m_MEM,
   input  logic [1:0]          wb_MEM,
   mem_access_stage_if.master  dmem,
   output logic                stall,
   output logic                pc_src,
   output logic [31:0]         read_data_wb,
   output logic [31:0]         alu_res_wb,
   output logic [4:0]          write_register_wb,
   output logic [1:0]          wb_WB,
   output logic                align_error,
   output logic                bus_error
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;

   logic        w_mem_op;
   logic        w_load;
   logic        w_misaligned;
   logic        w_timeout_hit;
   logic        w_req;
   logic        w_stall;

   logic [31:0] r_read_data_wb;
   logic [31:0] r_alu_res_wb;
   logic [4:0]  r_write_register_wb;
   logic [1:0]  r_wb_WB;
   logic        r_align_error;
   logic        r_bus_error;

   // Read+write together is treated as a write, so a load is read without write.
   assign w_mem_op      = m_MEM[0] | m_MEM[1];
   assign w_load        = m_MEM[0] & ~m_MEM[1];
   assign w_misaligned  = w_mem_op & (res[1:0] != 2'b00);
   assign w_timeout_hit = (r_state == WAIT) &
                          (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) & ~dmem.dmem_ack;
   assign w_req         = w_mem_op & ~w_misaligned & ~w_timeout_hit;
   assign w_stall       = w_req & ~dmem.dmem_ack;

   assign dmem.dmem_req   = w_req;
   assign dmem.dmem_we    = m_MEM[1];
   assign dmem.dmem_addr  = res;
   assign dmem.dmem_wdata = write_data_ex;

   assign stall  = w_stall;
   assign pc_src = m_MEM[2] & zero;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_req && !dmem.dmem_ack) begin
               w_state_nxt = WAIT;
               w_cnt_nxt   = '0;
            end
         end
         WAIT: begin
            // A dropped request can only come from illegal mid-wait stimulus; recover to IDLE.
            if (dmem.dmem_ack || w_timeout_hit || !w_req) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_read_data_wb      <= '0;
         r_alu_res_wb        <= '0;
         r_write_register_wb <= '0;
         r_wb_WB             <= '0;
         r_align_error       <= 1'b0;
         r_bus_error         <= 1'b0;
      end else begin
         r_align_error <= 1'b0;
         r_bus_error   <= 1'b0;
         if (w_stall) begin
            r_wb_WB <= '0;
         end else if (w_misaligned || w_timeout_hit) begin
            // Aborted access: squash writeback but keep the ALU result for debug visibility.
            r_wb_WB             <= '0;
            r_alu_res_wb        <= res;
            r_write_register_wb <= write_register;
            r_align_error       <= w_misaligned;
            r_bus_error         <= w_timeout_hit;
         end else begin
            r_wb_WB             <= wb_MEM;
            r_alu_res_wb        <= res;
            r_write_register_wb <= write_register;
            if (w_load && dmem.dmem_ack)
               r_read_data_wb <= dmem.dmem_rdata;
         end
      end
   end

   assign read_data_wb      = r_read_data_wb;
   assign alu_res_wb        = r_alu_res_wb;
   assign write_register_wb = r_write_register_wb;
   assign wb_WB             = r_wb_WB;
   assign align_error       = r_align_error;
   assign bus_error         = r_bus_error;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
   logic        clk;
   logic        reset;
   logic [31:0] res;
   logic        zero;
   logic [31:0] write_data_ex;
   logic [4:0]  write_register;
   logic [2:0]  m_MEM;
   logic [1:0]  wb_MEM;
   logic        stall;
   logic        pc_src;
   logic [31:0] read_data_wb;
   logic [31:0] alu_res_wb;
   logic [4:0]  write_register_wb;
   logic [1:0]  wb_WB;
   logic        align_error;
   logic        bus_error;

   int n_checks = 0;
   int n_errors = 0;
   int n_stall;

   mem_access_stage_if bus ();

   mem_access_stage #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .clk               (clk),
      .reset             (reset),
      .res               (res),
      .zero              (zero),
      .write_data_ex     (write_data_ex),
      .write_register    (write_register),
      .m_MEM             (m_MEM),
      .wb_MEM            (wb_MEM),
      .dmem              (bus.master),
      .stall             (stall),
      .pc_src            (pc_src),
      .read_data_wb      (read_data_wb),
      .alu_res_wb        (alu_res_wb),
      .write_register_wb (write_register_wb),
      .wb_WB             (wb_WB),
      .align_error       (align_error),
      .bus_error         (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_regs_zero(input string tag);
      chk({tag, " read_data_wb"},      read_data_wb, 32'h0);
      chk({tag, " alu_res_wb"},        alu_res_wb, 32'h0);
      chk({tag, " write_register_wb"}, 32'(write_register_wb), 32'h0);
      chk({tag, " wb_WB"},             32'(wb_WB), 32'h0);
      chk({tag, " align_error"},       32'(align_error), 32'h0);
      chk({tag, " bus_error"},         32'(bus_error), 32'h0);
   endtask

   initial begin
      reset          = 1'b1;
      res            = 32'h0;
      zero           = 1'b0;
      write_data_ex  = 32'h0;
      write_register = 5'd0;
      m_MEM          = 3'b000;
      wb_MEM         = 2'b00;
      bus.dmem_rdata = 32'h0;
      bus.dmem_ack   = 1'b0;

      // Reset state, and combinational outputs not gated by reset
      tick();
      tick();
      chk_regs_zero("reset");
      m_MEM = 3'b001;
      res   = 32'h100;
      #1;
      chk("reset req follows inputs", 32'(bus.dmem_req), 32'h1);
      chk("reset stall follows inputs", 32'(stall), 32'h1);
      tick();
      chk("reset wb_WB held 0", 32'(wb_WB), 32'h0);

      // ALU-only instruction
      reset          = 1'b0;
      m_MEM          = 3'b000;
      wb_MEM         = 2'b01;
      res            = 32'h1234;
      write_register = 5'd5;
      #1;
      chk("alu req", 32'(bus.dmem_req), 32'h0);
      chk("alu stall", 32'(stall), 32'h0);
      tick();
      chk("alu alu_res_wb", alu_res_wb, 32'h1234);
      chk("alu write_register_wb", 32'(write_register_wb), 32'h5);
      chk("alu wb_WB", 32'(wb_WB), 32'h1);

      // Zero-wait load
      m_MEM          = 3'b001;
      wb_MEM         = 2'b11;
      res            = 32'h100;
      write_register = 5'd7;
      bus.dmem_ack   = 1'b1;
      bus.dmem_rdata = 32'hDEADBEEF;
      #1;
      chk("load0 req", 32'(bus.dmem_req), 32'h1);
      chk("load0 we", 32'(bus.dmem_we), 32'h0);
      chk("load0 stall", 32'(stall), 32'h0);
      tick();
      chk("load0 read_data_wb", read_data_wb, 32'hDEADBEEF);
      chk("load0 wb_WB", 32'(wb_WB), 32'h3);
      chk("load0 write_register_wb", 32'(write_register_wb), 32'h7);

      // Store with 3 wait cycles
      m_MEM          = 3'b010;
      wb_MEM         = 2'b10;
      res            = 32'h200;
      write_data_ex  = 32'h55;
      write_register = 5'd2;
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = 32'h0BADF00D;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("store stall", 32'(stall), 32'h1);
         chk("store we", 32'(bus.dmem_we), 32'h1);
         chk("store addr", bus.dmem_addr, 32'h200);
         chk("store wdata", bus.dmem_wdata, 32'h55);
         tick();
         chk("store bubble wb_WB", 32'(wb_WB), 32'h0);
         chk("store hold alu_res_wb", alu_res_wb, 32'h100);
      end
      bus.dmem_ack = 1'b1;
      #1;
      chk("store ack stall", 32'(stall), 32'h0);
      chk("store ack req", 32'(bus.dmem_req), 32'h1);
      tick();
      chk("store done wb_WB", 32'(wb_WB), 32'h2);
      chk("store done alu_res_wb", alu_res_wb, 32'h200);
      chk("store keeps read_data_wb", read_data_wb, 32'hDEADBEEF);

      // Load that times out
      bus.dmem_ack   = 1'b0;
      m_MEM          = 3'b001;
      wb_MEM         = 2'b11;
      res            = 32'h300;
      write_register = 5'd9;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("timeout stall", 32'(stall), 32'h1);
         chk("timeout req", 32'(bus.dmem_req), 32'h1);
         tick();
         chk("timeout bubble wb_WB", 32'(wb_WB), 32'h0);
         chk("timeout no early bus_error", 32'(bus_error), 32'h0);
      end
      #1;
      chk("timeout cycle stall", 32'(stall), 32'h0);
      chk("timeout cycle req", 32'(bus.dmem_req), 32'h0);
      tick();
      chk("timeout bus_error", 32'(bus_error), 32'h1);
      chk("timeout wb_WB", 32'(wb_WB), 32'h0);
      chk("timeout alu_res_wb", alu_res_wb, 32'h300);
      chk("timeout write_register_wb", 32'(write_register_wb), 32'h9);
      chk("timeout read_data_wb held", read_data_wb, 32'hDEADBEEF);
      m_MEM          = 3'b000;
      wb_MEM         = 2'b01;
      res            = 32'h4;
      write_register = 5'd3;
      tick();
      chk("bus_error single pulse", 32'(bus_error), 32'h0);
      chk("after timeout wb_WB", 32'(wb_WB), 32'h1);

      // Misaligned load
      m_MEM          = 3'b001;
      wb_MEM         = 2'b11;
      res            = 32'h102;
      write_register = 5'd4;
      #1;
      chk("misalign req", 32'(bus.dmem_req), 32'h0);
      chk("misalign stall", 32'(stall), 32'h0);
      tick();
      chk("misalign align_error", 32'(align_error), 32'h1);
      chk("misalign bus_error", 32'(bus_error), 32'h0);
      chk("misalign wb_WB", 32'(wb_WB), 32'h0);
      chk("misalign alu_res_wb", alu_res_wb, 32'h102);
      chk("misalign write_register_wb", 32'(write_register_wb), 32'h4);

      // Branch redirect
      m_MEM  = 3'b100;
      wb_MEM = 2'b10;
      res    = 32'h8;
      zero   = 1'b1;
      #1;
      chk("branch taken pc_src", 32'(pc_src), 32'h1);
      chk("branch req", 32'(bus.dmem_req), 32'h0);
      tick();
      chk("align_error single pulse", 32'(align_error), 32'h0);
      chk("branch wb_WB", 32'(wb_WB), 32'h2);
      zero = 1'b0;
      #1;
      chk("branch not taken pc_src", 32'(pc_src), 32'h0);

      // Reset during WAIT with counter at 5
      m_MEM          = 3'b001;
      wb_MEM         = 2'b11;
      res            = 32'h400;
      write_register = 5'd6;
      bus.dmem_ack   = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      reset = 1'b1;
      #1;
      chk("reset-in-wait stall ungated", 32'(stall), 32'h1);
      tick();
      chk_regs_zero("reset-in-wait");
      reset = 1'b0;
      #1;
      chk("reissue req", 32'(bus.dmem_req), 32'h1);
      n_stall = 0;
      while (stall && n_stall < 40) begin
         n_stall++;
         tick();
      end
      chk("reissue full timeout stall count", 32'(n_stall), 32'd16);
      tick();
      chk("reissue bus_error", 32'(bus_error), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
